// File: rtl/ble_crc_chk_if.sv
// Bundle between the RX packet FSM (master) and the BLE CRC-24 checker (slave).
// The master drives packet framing and serial bits. The checker returns its LFSR and verdict.
interface ble_crc_chk_if #(
  parameter int LEN_W = 9
);
  logic             rx_start;
  logic [23:0]      ble_crc_init;
  logic [LEN_W-1:0] pdu_len;
  logic             rx_abort;
  logic             rx_bit;
  logic             rx_bit_vld;
  logic [23:0]      r_crc_lfsr;
  logic             busy;
  logic             crc_done;
  logic             crc_ok;
  logic             crc_err;

  modport master (
    output rx_start, ble_crc_init, pdu_len, rx_abort, rx_bit, rx_bit_vld,
    input  r_crc_lfsr, busy, crc_done, crc_ok, crc_err
  );

  modport slave (
    input  rx_start, ble_crc_init, pdu_len, rx_abort, rx_bit, rx_bit_vld,
    output r_crc_lfsr, busy, crc_done, crc_ok, crc_err
  );
endinterface

// File: rtl/ble_crc_chk.sv
// BLE CRC-24 receive checker: runs the PDU through the TX LFSR and then compares
// the 24 received CRC bits MSB-first against the register as it shifts out.
module ble_crc_chk #(
  parameter int LEN_W = 9,
  parameter int CNT_W = 12
) (
  input  logic          pka_1or2m_gclk,
  input  logic          r_rx_rst_n,
  ble_crc_chk_if.slave  crc_if
);

  // Low-order terms of x^24+x^10+x^9+x^6+x^4+x^3+x+1
  localparam logic [23:0] POLY_TAPS = 24'h00065B;

  typedef enum logic [1:0] {IDLE, PDU, CRC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [23:0]      lfsr_reg, lfsr_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0] len_bits_reg, len_bits_next;
  logic [4:0]       crc_cnt_reg, crc_cnt_next;
  logic             mismatch_reg, mismatch_next;
  logic             ok_reg, ok_next;
  logic             err_reg, err_next;

  logic             start_go;
  logic             abort_go;
  logic             pdu_last;
  logic             crc_last;
  logic             fb;
  logic             bit_mismatch;
  logic [23:0]      lfsr_pdu_step;
  logic [CNT_W-1:0] len_bits_in;
  logic             busy;
  logic             crc_done;

  // Abort dominates a coincident start: nothing is loaded.
  assign abort_go     = crc_if.rx_abort;
  assign start_go     = crc_if.rx_start & ~crc_if.rx_abort;
  assign len_bits_in  = CNT_W'(crc_if.pdu_len) << 3;
  assign pdu_last     = (bit_cnt_reg == (len_bits_reg - CNT_W'(1)));
  assign crc_last     = (crc_cnt_reg == 5'd23);
  assign fb           = crc_if.rx_bit ^ lfsr_reg[23];
  assign bit_mismatch = crc_if.rx_bit ^ lfsr_reg[23];

  assign lfsr_pdu_step[0] = fb;

  genvar gi;
  generate
    for (gi = 1; gi < 24; gi++) begin : g_lfsr
      if (POLY_TAPS[gi]) begin : g_tap
        assign lfsr_pdu_step[gi] = lfsr_reg[gi-1] ^ fb;
      end else begin : g_shift
        assign lfsr_pdu_step[gi] = lfsr_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge pka_1or2m_gclk or negedge r_rx_rst_n) begin
    if (!r_rx_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort_go) begin
      state_next = IDLE;
    end else if (start_go) begin
      state_next = (crc_if.pdu_len == '0) ? CRC : PDU;
    end else begin
      case (state_reg)
        PDU:     if (crc_if.rx_bit_vld && pdu_last) state_next = CRC;
        CRC:     if (crc_if.rx_bit_vld && crc_last) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    busy     = (state_reg == PDU) || (state_reg == CRC);
    crc_done = (state_reg == DONE);
  end

  always_comb begin
    lfsr_next     = lfsr_reg;
    bit_cnt_next  = bit_cnt_reg;
    len_bits_next = len_bits_reg;
    crc_cnt_next  = crc_cnt_reg;
    mismatch_next = mismatch_reg;
    ok_next       = ok_reg;
    err_next      = err_reg;
    if (abort_go) begin
      ok_next  = 1'b0;
      err_next = 1'b0;
    end else if (start_go) begin
      lfsr_next     = crc_if.ble_crc_init;
      bit_cnt_next  = '0;
      len_bits_next = len_bits_in;
      crc_cnt_next  = '0;
      mismatch_next = 1'b0;
      ok_next       = 1'b0;
      err_next      = 1'b0;
    end else if (crc_if.rx_bit_vld) begin
      case (state_reg)
        PDU: begin
          lfsr_next    = lfsr_pdu_step;
          bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          if (pdu_last) crc_cnt_next = '0;
        end
        CRC: begin
          // Shift-out compare: no feedback, the verdict includes the final bit.
          lfsr_next     = {lfsr_reg[22:0], 1'b0};
          mismatch_next = mismatch_reg | bit_mismatch;
          crc_cnt_next  = crc_cnt_reg + 5'd1;
          if (crc_last) begin
            ok_next  = ~mismatch_next;
            err_next = mismatch_next;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pka_1or2m_gclk or negedge r_rx_rst_n) begin
    if (!r_rx_rst_n) begin
      lfsr_reg     <= '0;
      bit_cnt_reg  <= '0;
      len_bits_reg <= '0;
      crc_cnt_reg  <= '0;
      mismatch_reg <= 1'b0;
      ok_reg       <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      lfsr_reg     <= lfsr_next;
      bit_cnt_reg  <= bit_cnt_next;
      len_bits_reg <= len_bits_next;
      crc_cnt_reg  <= crc_cnt_next;
      mismatch_reg <= mismatch_next;
      ok_reg       <= ok_next;
      err_reg      <= err_next;
    end
  end

  assign crc_if.r_crc_lfsr = lfsr_reg;
  assign crc_if.busy       = busy;
  assign crc_if.crc_done   = crc_done;
  assign crc_if.crc_ok     = ok_reg;
  assign crc_if.crc_err    = err_reg;

endmodule

// File: doc/ble_crc_chk.md
Name: ble_crc_chk

Overview:
- Receive-side BLE CRC-24 checker. It is the counterpart of the transmit CRC generator.
- Consumes the de-whitened bit-serial PDU from the RX bit path, LSB-first per byte, as delivered by the demodulator. It then consumes the 24 received CRC bits and flags pass/fail to the RX packet FSM.
- Uses the same polynomial and the same per-packet init value as TX, so a TX→RX loopback passes.

Parameters:
- LEN_W, 9, width of PDU byte-length input (max 511 bytes).
- CNT_W, 12, width of internal PDU bit counter (must hold LEN_W+3 bits).

Ports:
- pka_1or2m_gclk  in  1  bit clock (1 or 2 Mbps domain).
- r_rx_rst_n  in  1  asynchronous active-low reset.
- rx_start  in  1  one-cycle pulse: load init, begin new packet.
- ble_crc_init  in  24  LFSR init value (0x555555 for advertising, per-connection value otherwise).
- pdu_len  in  LEN_W  PDU length in bytes (header + payload), sampled on rx_start.
- rx_abort  in  1  drop current packet (sync loss / access-address miss).
- rx_bit  in  1  serial received bit.
- rx_bit_vld  in  1  rx_bit qualifier; may deassert for arbitrary gaps.
- r_crc_lfsr  out  24  current LFSR / comparison register.
- busy  out  1  high in PDU or CRC state.
- crc_done  out  1  one-cycle pulse at end of check.
- crc_ok  out  1  pass, held until next rx_start/abort/reset.
- crc_err  out  1  fail, held until next rx_start/abort/reset.

Behaviour:
- Reset (r_rx_rst_n=0, async): state=IDLE, r_crc_lfsr=0, counters=0, busy=crc_done=crc_ok=crc_err=0.
- States: IDLE, PDU, CRC, DONE. busy=1 in PDU and CRC only.
- rx_start in any state: r_crc_lfsr<=ble_crc_init, bit counter<=0, latch pdu_len*8, clear crc_ok/crc_err and mismatch flag. Go to PDU, or directly to CRC if pdu_len=0.
- rx_start and rx_abort in the same cycle: abort wins → IDLE, nothing loaded.
- PDU state, on each rx_bit_vld: fb=rx_bit^c[23]. Bits 0,1,3,4,6,9,10 take fb, XORed with c[n-1] for n>0. All other bits n take c[n-1]. Polynomial: x^24+x^10+x^9+x^6+x^4+x^3+x+1. Bit counter increments. When the accepted bit is bit number pdu_len*8-1 → CRC, with CRC bit counter=0.
- CRC state, on each rx_bit_vld: compare rx_bit with r_crc_lfsr[23]; a mismatch sets the sticky mismatch flag. Then r_crc_lfsr<={r_crc_lfsr[22:0],1'b0}, with no feedback (MSB-first, matching TX shift-out order). After the 24th bit → DONE.
- No vld: LFSR and counters hold in every state.
- DONE (exactly one cycle): crc_done=1. crc_ok=~mismatch, crc_err=mismatch, both registered and valid in the same cycle as crc_done. Then → IDLE, holding crc_ok/crc_err.
- Latency: crc_done is high the cycle after the clock edge that accepts the 24th CRC bit.
- rx_abort in PDU/CRC/DONE: → IDLE next edge. No crc_done. crc_ok=crc_err=0.
- rx_bit_vld in IDLE or DONE: ignored.
- crc_ok and crc_err are never both 1.
- Async reset mid-packet: immediate return to reset values; a new rx_start is needed.

Test Plan:
1. rx_start, init=0x555555, pdu_len=0. Feed 24 CRC bits of 0x555555 MSB-first → crc_done pulse 1 cycle after the 24th bit, crc_ok=1, crc_err=0.
2. Loopback: TX CRC generator and checker share init 0x555555. Send 2-byte header 0x40,0x06 plus a 6-byte payload with the TX-generated CRC → crc_ok=1. Flip CRC bit 7 → crc_err=1, crc_ok=0.
3. Same packet as scenario 2 with random rx_bit_vld gaps (1–5 idle cycles between bits) → identical r_crc_lfsr sequence per accepted bit and crc_ok=1.
4. rx_abort asserted at PDU bit 20 → busy=0 next cycle, no crc_done, crc_ok=crc_err=0. A following rx_start with a valid packet → crc_ok=1.
5. r_rx_rst_n pulsed low mid-CRC-phase → r_crc_lfsr=0x000000, state IDLE, all flags 0 immediately, without waiting for a clock edge.
6. rx_start and rx_abort asserted together in IDLE → remains IDLE, r_crc_lfsr unchanged. rx_start while in CRC state → reload init and restart from PDU bit 0.
